// File: rtl/bscan_chain_ctrl.sv
// Boundary-scan register bank: N_CH chains of LEN cells with update latches,
// per-chain bypass and a capture/shift/update sequencer driving the core scan enable.
module bscan_chain_ctrl #(
    parameter int unsigned N_CH = 7,
    parameter int unsigned LEN  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic                  start_i,
    input  logic [N_CH-1:0]       bypass_i,
    input  logic [N_CH-1:0]       scan_in_i,
    output logic [N_CH-1:0]       scan_out_o,
    input  logic [N_CH*LEN-1:0]   func_in_i,
    output logic [N_CH*LEN-1:0]   func_out_o,
    output logic                  scan_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_UPDATE  = 2'd3
    } state_e;

    state_e                   state_q;
    logic [N_CH-1:0][LEN-1:0] sr_q;
    logic [N_CH-1:0][LEN-1:0] upd_q;
    logic [N_CH-1:0]          bf_q;
    logic [N_CH-1:0]          bl_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     busy_q;
    logic                     scan_en_q;
    logic                     done_q;

    // Sequencer and chain storage; busy/scan_en/done are registered alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            upd_q     <= '0;
            bf_q      <= '0;
            bl_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            scan_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bl_q    <= bypass_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    sr_q      <= func_in_i;
                    bf_q      <= '0;
                    cnt_q     <= '0;
                    scan_en_q <= 1'b1;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    for (int c = 0; c < int'(N_CH); c++) begin
                        if (bl_q[c]) begin
                            bf_q[c] <= scan_in_i[c];
                        end else begin
                            // Serial data enters at cell 0 and moves toward cell LEN-1.
                            sr_q[c] <= LEN'({sr_q[c], scan_in_i[c]});
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        scan_en_q <= 1'b0;
                        state_q   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    for (int c = 0; c < int'(N_CH); c++) begin
                        if (!bl_q[c]) begin
                            upd_q[c] <= sr_q[c];
                        end
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Serial output: bypass flop for bypassed chains, last cell otherwise.
    always_comb begin
        scan_out_o = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            scan_out_o[c] = bl_q[c] ? bf_q[c] : sr_q[c][LEN-1];
        end
    end

    assign func_out_o = test_en_i ? upd_q : func_in_i;
    assign scan_en_o  = scan_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: doc/bscan_chain_ctrl.md
# bscan_chain_ctrl

Parametrised boundary-scan register bank with a built-in capture/shift/update sequencer. It is the next-generation replacement for hand-instantiated per-pin boundary cells around an ISCAS core. It provides N_CH independent chains of LEN cells each. Each cell has an update latch, so functional outputs hold steady while data shifts. Each chain also has a 1-bit bypass path. It sits between the core's pins and the chip scan ports and drives the core's scan enable.

## Interface
- N_CH, 7: number of parallel boundary chains.
- LEN, 6: cells per chain, ≥1. Counter width is ceil(log2(LEN)), minimum 1.
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- test_en  in  1  0: func_out = func_in. 1: func_out = update latches.
- start  in  1  request one capture-shift-update sequence. Sampled only in IDLE.
- bypass  in  N_CH  per-chain bypass select. Latched when start is accepted.
- scan_in  in  N_CH  serial input per chain.
- scan_out  out  N_CH  serial output per chain.
- func_in  in  N_CH*LEN  parallel capture data. Cell k of chain c is bit c*LEN+k.
- func_out  out  N_CH*LEN  parallel output (mux of func_in and update latches).
- scan_en  out  1  high exactly during SHIFT. Routes to the core's scan enable.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after UPDATE completes.

## Operation
- Storage per chain: shift register sr[LEN], update latch upd[LEN], bypass flop bf, latched bypass bl.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE.
  - IDLE→CAPTURE when start=1. On that edge, bl <= bypass.
  - CAPTURE→SHIFT unconditionally. On that edge: sr <= func_in slice; bf <= 0; cnt <= 0.
  - SHIFT→SHIFT while cnt < LEN-1. SHIFT→UPDATE when cnt == LEN-1. Each SHIFT edge: cnt++.
  - UPDATE→IDLE unconditionally. On that edge, upd <= sr for every chain with bl=0. Chains with bl=1 keep upd. done is set to 1.
- Shift edge, chain with bl=0: sr[0] <= scan_in[c]; sr[k] <= sr[k-1].
- Shift edge, chain with bl=1: bf <= scan_in[c]; sr holds.
- scan_out[c] = bl ? bf : sr[LEN-1]. This is combinational from flops. The first bit out is the captured cell LEN-1.
- After LEN shifts, the first bit shifted in sits in cell LEN-1.
- func_out = test_en ? upd : func_in. It is combinational. test_en may change at any time without affecting the FSM.
- upd changes only on the UPDATE edge, so func_out is glitch-free during SHIFT.
- start during a non-IDLE state is ignored and not queued.
- start=1 in the IDLE cycle where done=1 is accepted, giving back-to-back sequences.
- bypass changes during a sequence have no effect until the next accepted start.

## Timing
- Reset values: state IDLE, sr=0, upd=0, bf=0, bl=0, cnt=0, done=0.
  - Outputs under reset: busy=0, scan_en=0, scan_out=0, func_out=(test_en ? 0 : func_in).
- Cycle numbering: start is sampled high at edge E0.
  - Cycle 1 is CAPTURE.
  - Cycles 2..LEN+1 are SHIFT, with shifts at edges E2..E(LEN+1).
  - Cycle LEN+2 is UPDATE.
  - done is high in cycle LEN+3.
- busy is high in cycles 1..LEN+2. scan_en is high in cycles 2..LEN+1.
- Reset mid-sequence: everything clears immediately. No UPDATE occurs and no done pulse is produced.
- LEN=1: exactly one SHIFT cycle.

## Test plan
Bench parameters: N_CH=2, LEN=4, test_en=1.
- **Reset:** RST=1 with start=1 and scan_in=2'b11 → busy=0, scan_en=0, done=0, scan_out=0, func_out=0. With test_en=0, func_out equals func_in.
- **Capture/shift/update:**
  - Stimulus: chain0 func_in=4'b1010; start pulse; scan_in[0] = 1,1,0,0 over the SHIFT cycles.
  - scan_out[0] over the SHIFT cycles = 1,0,1,0.
  - scan_en is high exactly cycles 2-5.
  - done pulses in cycle 7.
  - func_out chain0 becomes 4'b1100 in cycle 7.
- **Hold during shift:** with upd chain0=4'b0110 from a prior sequence, func_out stays 4'b0110 through cycles 1-6 of a new sequence and changes only after the UPDATE edge.
- **Bypass:**
  - Stimulus: bypass=2'b10 at start; scan_in[1] = 1,0,1,1.
  - scan_out[1] = 0,1,0,1; the first bit is 0 because bf is cleared at CAPTURE.
  - upd chain1 is unchanged while chain0 updates normally.
  - Toggling bypass mid-SHIFT has no effect.
- **Start handling:** start held high continuously.
  - Sequences run back-to-back: done in cycle 7 coincides with acceptance, and CAPTURE follows in cycle 8.
  - A start pulse during SHIFT alone produces no extra sequence.
- **Reset mid-SHIFT:** assert RST in cycle 3 → immediate IDLE with upd=0. No done pulse. The next start runs a full normal sequence.
